// File: rtl/spdif_pkg.sv
// Shared types and constants for the S/PDIF stereo packing stage.
// Holds the pairing FSM states, the channel-status field and the bit-index helper.
package spdif_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        WAIT_L   = 2'd1,
        HAVE_L   = 2'd2
    } pair_state_t;

    localparam int CS_BITS   = 192;
    localparam int CS_FS_LSB = 24;
    localparam int CS_FS_MSB = 27;
    localparam int FS_W      = CS_FS_MSB - CS_FS_LSB + 1;

    // Status bit n is carried at cdata_i[191-n].
    function automatic int cs_idx(input int n);
        return CS_BITS - 1 - n;
    endfunction

endpackage

// File: rtl/spdif_pair_fifo.sv
// Generic show-ahead synchronous FIFO with registered pointers.
// Ports: clk, rst, push/wdata, pop, full, empty, rdata (head, 0 while empty).
module spdif_pair_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_pop;
    logic                do_push;

    assign empty = (wr_ptr == rd_ptr);
    // Same index, different lap bit: writer is one full lap ahead.
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);

    assign do_pop  = pop && !empty;
    // A pop frees the slot the push lands in when full.
    assign do_push = push && (!full || do_pop);

    assign rdata = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[DEPTH_LOG2-1:0]] <= wdata;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spdif_stereo_pack.sv
// Pairs left/right S/PDIF subframes into stereo samples behind a FIFO.
// Ports: clk, rst, data_i/ack_i/lrck_i/locked_i/cdata_i from receiver;
// left_o/right_o/valid_o/ready_i to mixer; locked_o, fs_code_o, counters.
module spdif_stereo_pack
    import spdif_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [23:0]          data_i,
    input  logic                 ack_i,
    input  logic                 lrck_i,
    input  logic                 locked_i,
    input  logic [CS_BITS-1:0]   cdata_i,
    output logic [23:0]          left_o,
    output logic [23:0]          right_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 locked_o,
    output logic [FS_W-1:0]      fs_code_o,
    output logic [CNT_W-1:0]     overflow_cnt_o,
    output logic [CNT_W-1:0]     slip_cnt_o
);

    localparam int FS_HI = CS_BITS - 1 - CS_FS_LSB;
    localparam int FS_LO = CS_BITS - 1 - CS_FS_MSB;

    pair_state_t state;
    pair_state_t next_state;
    logic [23:0] pend_left;
    logic        push_req;
    logic        load_left;
    logic        slip_inc;
    logic        ovf_inc;
    logic        pop;
    logic        full;
    logic        empty;
    logic [47:0] head;
    logic        unused_cs;

    assign unused_cs = ^{cdata_i[CS_BITS-1:FS_HI+1], cdata_i[FS_LO-1:0]};

    spdif_pair_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (48)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_req),
        .wdata ({pend_left, data_i}),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .rdata (head)
    );

    assign valid_o = !empty;
    assign pop     = valid_o && ready_i;
    assign left_o  = head[47:24];
    assign right_o = head[23:0];
    assign ovf_inc = push_req && full && !pop;

    always_comb begin
        next_state = state;
        push_req   = 1'b0;
        load_left  = 1'b0;
        slip_inc   = 1'b0;
        // Losing lock overrides any strobe in the same cycle.
        if (!locked_i) begin
            next_state = UNLOCKED;
        end else begin
            unique case (state)
                UNLOCKED: next_state = WAIT_L;
                WAIT_L: begin
                    if (ack_i && !lrck_i) begin
                        load_left  = 1'b1;
                        next_state = HAVE_L;
                    end else if (ack_i) begin
                        slip_inc = 1'b1;
                    end
                end
                HAVE_L: begin
                    if (ack_i && lrck_i) begin
                        push_req   = 1'b1;
                        next_state = WAIT_L;
                    end else if (ack_i) begin
                        load_left = 1'b1;
                        slip_inc  = 1'b1;
                    end
                end
                default: next_state = UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= UNLOCKED;
            pend_left      <= '0;
            locked_o       <= 1'b0;
            fs_code_o      <= '0;
            overflow_cnt_o <= '0;
            slip_cnt_o     <= '0;
        end else begin
            state    <= next_state;
            locked_o <= locked_i;
            if (load_left) begin
                pend_left <= data_i;
            end
            if (locked_i) begin
                for (int k = 0; k < FS_W; k++) begin
                    fs_code_o[k] <= cdata_i[cs_idx(CS_FS_LSB + k)];
                end
            end
            if (slip_inc && slip_cnt_o != '1) begin
                slip_cnt_o <= slip_cnt_o + 1'b1;
            end
            if (ovf_inc && overflow_cnt_o != '1) begin
                overflow_cnt_o <= overflow_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spdif_stereo_pack.sv
// Self-checking bench for spdif_stereo_pack.
// Directed steps plus random traffic against a queue-based reference model.
module tb_spdif_stereo_pack;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [23:0]  data_i;
    logic         ack_i;
    logic         lrck_i;
    logic         locked_i;
    logic [191:0] cdata_i;
    logic [23:0]  left_o;
    logic [23:0]  right_o;
    logic         valid_o;
    logic         ready_i;
    logic         locked_o;
    logic [3:0]   fs_code_o;
    logic [7:0]   overflow_cnt_o;
    logic [7:0]   slip_cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [47:0] q[$];
    bit          m_active;
    bit          m_have;
    logic [23:0] m_pend;
    int          m_slip;
    int          m_ovf;
    logic [3:0]  m_fs;
    logic        m_lock;

    always #5 clk = ~clk;

    spdif_stereo_pack #(
        .FIFO_DEPTH_LOG2 (2),
        .CNT_W           (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .data_i         (data_i),
        .ack_i          (ack_i),
        .lrck_i         (lrck_i),
        .locked_i       (locked_i),
        .cdata_i        (cdata_i),
        .left_o         (left_o),
        .right_o        (right_o),
        .valid_o        (valid_o),
        .ready_i        (ready_i),
        .locked_o       (locked_o),
        .fs_code_o      (fs_code_o),
        .overflow_cnt_o (overflow_cnt_o),
        .slip_cnt_o     (slip_cnt_o)
    );

    task automatic chk(input string tag, input logic [47:0] obs,
                       input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] rand_cs();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_edge();
        bit pop;
        if (rst) begin
            q.delete();
            m_active = 0;
            m_have   = 0;
            m_pend   = '0;
            m_slip   = 0;
            m_ovf    = 0;
            m_fs     = '0;
            m_lock   = 0;
            return;
        end
        pop    = (q.size() > 0) && ready_i;
        m_lock = locked_i;
        if (locked_i) begin
            for (int k = 0; k < 4; k++) m_fs[k] = cdata_i[191 - (24 + k)];
        end
        if (pop) void'(q.pop_front());
        if (!locked_i) begin
            m_active = 0;
            m_have   = 0;
        end else if (!m_active) begin
            m_active = 1;
        end else if (ack_i) begin
            if (!lrck_i) begin
                if (m_have && m_slip < 255) m_slip++;
                m_pend = data_i;
                m_have = 1;
            end else if (m_have) begin
                m_have = 0;
                if (q.size() < DEPTH) q.push_back({m_pend, data_i});
                else if (m_ovf < 255) m_ovf++;
            end else if (m_slip < 255) begin
                m_slip++;
            end
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, ".valid"}, 48'(valid_o), 48'(q.size() > 0));
        if (q.size() > 0) begin
            chk({tag, ".left"}, 48'(left_o), 48'(q[0][47:24]));
            chk({tag, ".right"}, 48'(right_o), 48'(q[0][23:0]));
        end
        chk({tag, ".lock"}, 48'(locked_o), 48'(m_lock));
        chk({tag, ".fs"}, 48'(fs_code_o), 48'(m_fs));
        chk({tag, ".ovf"}, 48'(overflow_cnt_o), 48'(m_ovf));
        chk({tag, ".slip"}, 48'(slip_cnt_o), 48'(m_slip));
    endtask

    task automatic step(input string tag, input bit r, input bit ack,
                        input bit lr, input logic [23:0] d,
                        input bit lk, input bit rdy);
        rst      = r;
        ack_i    = ack;
        lrck_i   = lr;
        data_i   = d;
        locked_i = lk;
        ready_i  = rdy;
        @(posedge clk);
        model_edge();
        #1;
        compare(tag);
    endtask

    task automatic idle(input string tag, input bit lk, input bit rdy);
        step(tag, 0, 0, 0, 24'h0, lk, rdy);
    endtask

    initial begin
        cdata_i = rand_cs();
        step("rst0", 1, 0, 0, 24'h0, 0, 0);
        step("rst1", 1, 0, 0, 24'h0, 0, 0);
        chk("rst.left0", 48'(left_o), 48'h0);
        chk("rst.right0", 48'(right_o), 48'h0);

        // Basic pair
        idle("lock", 1, 0);
        step("basic.L", 0, 1, 0, 24'h123456, 1, 0);
        step("basic.R", 0, 1, 1, 24'hABCDEF, 1, 0);
        chk("basic.pair", {left_o, right_o}, 48'h123456ABCDEF);
        chk("basic.valid", 48'(valid_o), 48'h1);
        idle("basic.pop", 1, 1);
        chk("basic.empty", 48'(valid_o), 48'h0);

        // Misalignment R, L, L, R
        step("slip.R1", 0, 1, 1, 24'd1, 1, 0);
        step("slip.L2", 0, 1, 0, 24'd2, 1, 0);
        step("slip.L3", 0, 1, 0, 24'd3, 1, 0);
        step("slip.R4", 0, 1, 1, 24'd4, 1, 0);
        chk("slip.cnt", 48'(slip_cnt_o), 48'd2);
        chk("slip.pair", {left_o, right_o}, {24'd3, 24'd4});
        idle("slip.pop", 1, 1);
        chk("slip.single", 48'(valid_o), 48'h0);

        // Overflow with depth 4
        for (int i = 0; i < 6; i++) begin
            step("ovf.L", 0, 1, 0, 24'(16 + i), 1, 0);
            step("ovf.R", 0, 1, 1, 24'(32 + i), 1, 0);
        end
        chk("ovf.cnt", 48'(overflow_cnt_o), 48'd2);
        chk("ovf.head", {left_o, right_o}, {24'd16, 24'd32});
        step("ovf.L2", 0, 1, 0, 24'h777, 1, 0);
        step("ovf.pushpop", 0, 1, 1, 24'h888, 1, 1);
        chk("ovf.same", 48'(overflow_cnt_o), 48'd2);
        chk("ovf.size", 48'(q.size()), 48'(DEPTH));
        for (int i = 0; i < 5; i++) idle("ovf.drain", 1, 1);

        // Unlock with pending left
        step("ul.L", 0, 1, 0, 24'h0AAAAA, 1, 0);
        step("ul.Lq", 0, 1, 0, 24'h0AAAA1, 1, 0);
        step("ul.Rq", 0, 1, 1, 24'h0BBBB1, 1, 0);
        step("ul.L2", 0, 1, 0, 24'h0CCCCC, 1, 0);
        for (int i = 0; i < 3; i++) idle("ul.off", 0, 0);
        idle("ul.relock", 1, 0);
        step("ul.R", 0, 1, 1, 24'h0DDDDD, 1, 0);
        chk("ul.kept", {left_o, right_o}, {24'h0AAAA1, 24'h0BBBB1});
        idle("ul.pop", 1, 1);
        chk("ul.nopair", 48'(valid_o), 48'h0);

        // Channel-status sample-rate code
        cdata_i = '0;
        cdata_i[164] = 1'b1;
        idle("fs.load", 1, 0);
        chk("fs.code", 48'(fs_code_o), 48'b1000);
        idle("fs.unlock", 0, 0);
        cdata_i = rand_cs();
        idle("fs.hold1", 0, 0);
        idle("fs.hold2", 0, 0);
        chk("fs.held", 48'(fs_code_o), 48'b1000);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) cdata_i = rand_cs();
            step("rnd", 0, 1'($urandom_range(0, 3) != 0), 1'($urandom),
                 24'($urandom), $urandom_range(0, 19) != 0,
                 $urandom_range(0, 2) == 0);
        end

        // Reset mid-pair with full FIFO
        idle("mid.lock", 1, 0);
        for (int i = 0; i < DEPTH; i++) begin
            step("mid.L", 0, 1, 0, 24'($urandom), 1, 0);
            step("mid.R", 0, 1, 1, 24'($urandom), 1, 0);
        end
        step("mid.Lp", 0, 1, 0, 24'h55AA55, 1, 0);
        step("mid.rst", 1, 1, 1, 24'h123123, 1, 1);
        chk("mid.left0", 48'(left_o), 48'h0);
        chk("mid.right0", 48'(right_o), 48'h0);
        chk("mid.valid0", 48'(valid_o), 48'h0);
        chk("mid.fs0", 48'(fs_code_o), 48'h0);

        // Slip counter saturation
        idle("sat.lock", 1, 0);
        for (int i = 0; i < 300; i++) step("sat.R", 0, 1, 1, 24'(i), 1, 0);
        chk("sat.slip", 48'(slip_cnt_o), 48'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
